seq_det_prog: RTL
=================

Name: seq_det_prog

Overview:
Programmable serial pattern detector; successor to the fixed 2-bit-state "101" Moore detector.
- Pattern, length (1..MAX_LEN) and overlap mode are runtime-loadable.
- Input is qualified by a valid strobe; a saturating match counter is included.
- Sits on a serial bit stream in front of framing/sync logic. Reset configuration is "101", overlapping, so it drops in for the old block.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (>=2).
- LEN_W, 4, width of length fields; must hold MAX_LEN.
- CNT_W, 8, match counter width.
- RST_PATTERN, 8'b0000_0101, pattern after reset, right-aligned.
- RST_LEN, 3, pattern length after reset.
- RST_OVERLAP, 1, overlap mode after reset.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-low
- x_valid  in  1  sample strobe; x accepted on a clock edge with x_valid=1
- x  in  1  serial data bit
- cfg_load  in  1  one-cycle strobe; latch cfg_* fields
- cfg_pattern  in  MAX_LEN  pattern, right-aligned; bit cfg_len-1 is received first, bit 0 last
- cfg_len  in  LEN_W  pattern length, legal 1..MAX_LEN
- cfg_overlap  in  1  1 = overlapping matches, 0 = history discarded after a match
- cnt_clr  in  1  synchronous clear of match_cnt
- y  out  1  registered detect pulse
- match_cnt  out  CNT_W  saturating count of matches
- cfg_err  out  1  one-cycle pulse when an illegal cfg_len is loaded

Behaviour:
- Reset (rst=0, async):
  - Internal state: pat=RST_PATTERN, len=RST_LEN, ovl=RST_OVERLAP, hist=0, fill=0.
  - Outputs: y=0, match_cnt=0, cfg_err=0.
- History update:
  - hist is a MAX_LEN-bit shift register; an accepted sample does hist_n = {hist[MAX_LEN-2:0], x}.
  - fill counts valid history bits, saturating at len.
  - Effective state is FILL (fill<len) or ARMED (fill==len); encode as an explicit 2-state FSM plus fill.
- Match condition, evaluated on an accepted sample: (fill+1 >= len) and hist_n[len-1:0] == pat[len-1:0]. Only the low len bits are compared; upper bits are don't-care.
- Detect output:
  - y=1 in the cycle immediately after the edge that accepted the completing sample (1-cycle latency, Moore-style, registered).
  - y=0 in every other cycle, including cycles with x_valid=0.
- On a match:
  - match_cnt increments, saturating at all-ones (no wrap).
  - ovl=1: fill stays len, so the next sample can complete another match (e.g. 10101 gives 2 matches for "101").
  - ovl=0: fill<=0 and the state returns to FILL.
- Samples with x_valid=0 leave hist, fill and the state unchanged.
- Configuration load (cfg_load=1, cfg_len legal):
  - Latch pat, len, ovl; fill<=0; state FILL; y<=0.
  - A sample presented in the same cycle is dropped.
  - match_cnt is unaffected.
- Configuration load with cfg_len==0 or cfg_len>MAX_LEN:
  - Config is rejected and the old config kept.
  - cfg_err=1 for one cycle; the history and any concurrent sample are processed normally.
- cnt_clr=1: match_cnt<=0. If a match occurs in the same cycle, the clear wins (count=0), but y still pulses.
- len=1: every accepted sample equal to pat[0] is a match, in consecutive cycles when x_valid is held high.
- Reset asserted mid-stream: immediate return to the reset config and empty history; no y pulse is generated from a partial history.

Decomposition:
- Package seq_det_pkg holds:
  - FSM state encoding (ST_FILL, ST_ARMED).
  - Default-config constants (RST_PATTERN/LEN/OVERLAP values for "101").
  - A length-mask helper function (len -> MAX_LEN-bit compare mask).
- One natural sub-module: seq_det_sat_cnt (CNT_W saturating counter with clr/inc, clear priority), reusable by other PBL detectors.
- The shift-history/compare and the FSM stay in the top module.

Test Plan:
- Reset, then default config, stream 1,0,1,0,1 (all valid) -> y pulses 1 cycle after the 3rd and 5th samples; match_cnt=2.
- Load pattern 8'b0000_1101, len=4, ovl=0; stream 1,1,0,1,1,0,1 -> one y pulse (after the 4th sample); the trailing 1,0,1 does not match because history was cleared; match_cnt=1.
- Same stream with ovl=1 -> y after the 4th and 7th samples; match_cnt=2.
- Default config, stream 1,0 then x_valid=0 for 5 cycles, then 1 -> no y during the gap; y 1 cycle after the final accepted sample; match_cnt=1.
- cfg_load with cfg_len=0 -> cfg_err pulses, old config kept, stream 1,0,1 still matches. cfg_load asserted while a completing sample is presented -> sample dropped, no y pulse.
- CNT_W=2, len=1, pat=1, x=1 valid for 5 cycles -> y high 5 cycles, match_cnt saturates at 3. cnt_clr on a match cycle -> match_cnt=0, y=1. rst low mid-pattern -> y=0, match_cnt=0 immediately.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared definitions for the programmable serial pattern detector family.
//   state_t      : detector FSM state (history filling vs. armed)
//   DEF_*        : power-on configuration, the legacy "101" overlapping detector
//   len_mask()   : pattern length -> compare mask with the low 'len' bits set
package seq_det_pkg;

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_ARMED = 1'b1
    } state_t;

    localparam logic [7:0]  DEF_PATTERN = 8'b0000_0101;
    localparam int unsigned DEF_LEN     = 3;
    localparam logic        DEF_OVERLAP = 1'b1;

    // Mask is produced wide and truncated by the caller to its own MAX_LEN.
    localparam int unsigned MASK_W = 32;

    function automatic logic [MASK_W-1:0] len_mask(input int unsigned len);
        logic [MASK_W-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MASK_W; i++) begin
            if (i < len) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/seq_det_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active-low
//   clr  : synchronous clear
//   inc  : increment request (ignored once the count is all-ones)
//   cnt  : current count
module seq_det_sat_cnt #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seq_det_prog.sv
// Programmable serial pattern detector with runtime-loadable pattern, length
// and overlap mode. Drop-in successor of the fixed "101" Moore detector.
//   clk, rst     : clock (rising edge), asynchronous active-low reset
//   x_valid, x   : qualified serial input bit
//   cfg_load     : strobe latching cfg_pattern / cfg_len / cfg_overlap
//   cfg_pattern  : right-aligned pattern, bit cfg_len-1 received first
//   cfg_len      : pattern length, legal 1..MAX_LEN
//   cfg_overlap  : 1 = overlapping matches, 0 = history discarded after a match
//   cnt_clr      : synchronous clear of match_cnt (wins over a same-cycle match)
//   y            : registered one-cycle detect pulse
//   match_cnt    : saturating match count
//   cfg_err      : one-cycle pulse when an illegal cfg_len is loaded
module seq_det_prog
    import seq_det_pkg::*;
#(
    parameter int unsigned          MAX_LEN     = 8,
    parameter int unsigned          LEN_W       = 4,
    parameter int unsigned          CNT_W       = 8,
    parameter logic [MAX_LEN-1:0]   RST_PATTERN = MAX_LEN'(DEF_PATTERN),
    parameter int unsigned          RST_LEN     = DEF_LEN,
    parameter logic                 RST_OVERLAP = DEF_OVERLAP
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               x_valid,
    input  logic               x,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               cnt_clr,
    output logic               y,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               cfg_err
);

    state_t               state_q, state_n;
    logic [MAX_LEN-1:0]   pat_q, pat_n;
    logic [MAX_LEN-1:0]   hist_q, hist_n;
    logic [LEN_W-1:0]     len_q, len_n;
    logic [LEN_W-1:0]     fill_q, fill_n;
    logic                 ovl_q, ovl_n;
    logic                 y_q, y_n;
    logic                 err_q, err_n;

    logic                 cfg_legal;
    logic                 cfg_take;
    logic                 accept;
    logic                 reach;
    logic                 match;
    logic [MAX_LEN-1:0]   hist_shift;
    logic [MAX_LEN-1:0]   cmp_mask;

    assign cfg_legal  = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
    assign cfg_take   = cfg_load && cfg_legal;
    // A legal config load drops any sample presented in the same cycle.
    assign accept     = x_valid && !cfg_take;
    assign hist_shift = MAX_LEN'({hist_q, x});
    assign cmp_mask   = MAX_LEN'(len_mask(32'(len_q)));
    assign reach      = ({1'b0, fill_q} + 1'b1) >= {1'b0, len_q};
    assign match      = accept && reach &&
                        (((hist_shift ^ pat_q) & cmp_mask) == '0);

    always_comb begin
        state_n = state_q;
        pat_n   = pat_q;
        hist_n  = hist_q;
        len_n   = len_q;
        fill_n  = fill_q;
        ovl_n   = ovl_q;
        y_n     = 1'b0;
        err_n   = cfg_load && !cfg_legal;

        if (cfg_take) begin
            pat_n   = cfg_pattern;
            len_n   = cfg_len;
            ovl_n   = cfg_overlap;
            fill_n  = '0;
            state_n = ST_FILL;
        end else if (accept) begin
            hist_n = hist_shift;
            y_n    = match;
            if (match && !ovl_q) begin
                fill_n  = '0;
                state_n = ST_FILL;
            end else begin
                if (state_q == ST_FILL) begin
                    fill_n = fill_q + 1'b1;
                end
                state_n = (fill_n == len_q) ? ST_ARMED : ST_FILL;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_FILL;
            pat_q   <= RST_PATTERN;
            hist_q  <= '0;
            len_q   <= LEN_W'(RST_LEN);
            fill_q  <= '0;
            ovl_q   <= RST_OVERLAP;
            y_q     <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            pat_q   <= pat_n;
            hist_q  <= hist_n;
            len_q   <= len_n;
            fill_q  <= fill_n;
            ovl_q   <= ovl_n;
            y_q     <= y_n;
            err_q   <= err_n;
        end
    end

    assign y       = y_q;
    assign cfg_err = err_q;

    seq_det_sat_cnt #(
        .W(CNT_W)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (match),
        .cnt (match_cnt)
    );

endmodule
